// File: rtl/active_device_monitor.sv
// -----------------------------------------------------------------------------
// active_device_monitor
//
// Tracks how many devices are currently active from per-channel on/off event
// strobes. Every cycle the net change (devices switched on minus devices
// switched off) is added to the running count, which saturates at 0 and at
// MAX_COUNT instead of wrapping. Saturation events are remembered in sticky
// ovf/udf flags, the highest count seen is kept in peak_out, and a two-state
// hysteresis FSM raises alarm at HI_THRESH and drops it at LO_THRESH.
//
// Ports:
//   clk         in   1      rising-edge clock
//   rst         in   1      asynchronous, active-high reset
//   change      in   N_CH   per-channel event strobe (1 = one device change)
//   on_off      in   N_CH   per-channel direction (1 = on/+1, 0 = off/-1)
//   clr_flags   in   1      clears ovf/udf and re-arms the peak tracker
//   counter_out out  WIDTH  active-device count (registered)
//   peak_out    out  WIDTH  highest count since reset or last clr_flags
//   alarm       out  1      high-occupancy alarm with hysteresis
//   ovf         out  1      sticky: a cycle's result exceeded MAX_COUNT
//   udf         out  1      sticky: a cycle's result went below zero
// -----------------------------------------------------------------------------
module active_device_monitor #(
  parameter int WIDTH     = 8,
  parameter int N_CH      = 4,
  parameter int MAX_COUNT = 2**WIDTH - 1,
  parameter int HI_THRESH = 200,
  parameter int LO_THRESH = 150
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_CH-1:0]  change,
  input  logic [N_CH-1:0]  on_off,
  input  logic             clr_flags,
  output logic [WIDTH-1:0] counter_out,
  output logic [WIDTH-1:0] peak_out,
  output logic             alarm,
  output logic             ovf,
  output logic             udf
);

  // Width of a per-cycle popcount (0..N_CH).
  localparam int CW = $clog2(N_CH + 1);
  // Signed working width: count plus the largest possible step plus a sign
  // bit and one guard bit, so count + ups - downs can never wrap.
  localparam int SW = WIDTH + CW + 2;

  localparam logic signed [SW-1:0] MAX_S = SW'(MAX_COUNT);
  localparam logic [WIDTH-1:0]     MAX_W = WIDTH'(MAX_COUNT);
  localparam logic [WIDTH-1:0]     HI_W  = WIDTH'(HI_THRESH);
  localparam logic [WIDTH-1:0]     LO_W  = WIDTH'(LO_THRESH);

  typedef enum logic {
    NORMAL = 1'b0,
    ALARM  = 1'b1
  } state_t;

  logic [WIDTH-1:0]     r_count;
  logic [WIDTH-1:0]     r_peak;
  logic                 r_alarm;
  logic                 r_ovf;
  logic                 r_udf;
  state_t               r_state;

  logic [CW-1:0]        w_ups;
  logic [CW-1:0]        w_downs;
  logic signed [SW-1:0] w_raw;
  logic                 w_ovf_hit;
  logic                 w_udf_hit;
  logic [WIDTH-1:0]     w_next_count;

  // NOTE: every signal written here gets a default first, so no path through
  // the block leaves it unassigned and no latch is inferred.
  always_comb begin
    w_ups   = '0;
    w_downs = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (change[i]) begin
        if (on_off[i]) w_ups   = w_ups   + CW'(1);
        else           w_downs = w_downs + CW'(1);
      end
    end

    w_raw     = $signed(SW'(r_count)) + $signed(SW'(w_ups)) - $signed(SW'(w_downs));
    w_ovf_hit = (w_raw > MAX_S);
    w_udf_hit = (w_raw < 0);

    if (w_udf_hit)      w_next_count = '0;
    else if (w_ovf_hit) w_next_count = MAX_W;
    else                w_next_count = w_raw[WIDTH-1:0];
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
      r_peak  <= '0;
      r_ovf   <= 1'b0;
      r_udf   <= 1'b0;
      r_state <= NORMAL;
      r_alarm <= 1'b0;
    end else begin
      r_count <= w_next_count;

      // A flag whose condition occurs in the same cycle as clr_flags stays set.
      r_ovf <= w_ovf_hit | (r_ovf & ~clr_flags);
      r_udf <= w_udf_hit | (r_udf & ~clr_flags);

      // Peak tracks the count being loaded this edge, so it never lags.
      if (clr_flags || (w_next_count > r_peak)) r_peak <= w_next_count;

      // Thresholds are evaluated on the incoming count so alarm moves on the
      // same edge as counter_out crosses them.
      case (r_state)
        NORMAL: begin
          if (w_next_count >= HI_W) begin
            r_state <= ALARM;
            r_alarm <= 1'b1;
          end
        end
        ALARM: begin
          if (w_next_count <= LO_W) begin
            r_state <= NORMAL;
            r_alarm <= 1'b0;
          end
        end
        default: begin
          r_state <= NORMAL;
          r_alarm <= 1'b0;
        end
      endcase
    end
  end

  assign counter_out = r_count;
  assign peak_out    = r_peak;
  assign alarm       = r_alarm;
  assign ovf         = r_ovf;
  assign udf         = r_udf;

endmodule

// File: tb/tb_active_device_monitor.sv
// -----------------------------------------------------------------------------
// tb_active_device_monitor
//
// Directed bench for active_device_monitor at default parameters. Inputs are
// driven 1 time unit after each rising edge; outputs are sampled 1 time unit
// after the edge that loads them. Expected values are written out by hand.
// -----------------------------------------------------------------------------
module tb_active_device_monitor;

  logic       clk;
  logic       rst;
  logic [3:0] change;
  logic [3:0] on_off;
  logic       clr_flags;
  logic [7:0] counter_out;
  logic [7:0] peak_out;
  logic       alarm;
  logic       ovf;
  logic       udf;

  int n_checks = 0;
  int n_errors = 0;

  active_device_monitor dut (
    .clk         (clk),
    .rst         (rst),
    .change      (change),
    .on_off      (on_off),
    .clr_flags   (clr_flags),
    .counter_out (counter_out),
    .peak_out    (peak_out),
    .alarm       (alarm),
    .ovf         (ovf),
    .udf         (udf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock with the given inputs; returns 1 time unit after the edge with
  // inputs back at idle.
  task automatic cycle(input logic [3:0] ch, input logic [3:0] oo, input logic clr);
    change    = ch;
    on_off    = oo;
    clr_flags = clr;
    @(posedge clk);
    #1;
    change    = '0;
    on_off    = '0;
    clr_flags = 1'b0;
  endtask

  task automatic inc_by(input int n);
    int rem = n;
    while (rem >= 4) begin
      cycle(4'b1111, 4'b1111, 1'b0);
      rem -= 4;
    end
    if (rem > 0) cycle(4'((1 << rem) - 1), 4'((1 << rem) - 1), 1'b0);
  endtask

  task automatic dec_by(input int n);
    int rem = n;
    while (rem >= 4) begin
      cycle(4'b1111, 4'b0000, 1'b0);
      rem -= 4;
    end
    if (rem > 0) cycle(4'((1 << rem) - 1), 4'b0000, 1'b0);
  endtask

  task automatic check_all(input string tag, input int cnt, input int pk,
                           input logic al, input logic ov, input logic ud);
    check({tag, ".count"}, 32'(counter_out), 32'(cnt));
    check({tag, ".peak"},  32'(peak_out),    32'(pk));
    check({tag, ".alarm"}, 32'(alarm),       32'(al));
    check({tag, ".ovf"},   32'(ovf),         32'(ov));
    check({tag, ".udf"},   32'(udf),         32'(ud));
  endtask

  initial begin
    rst       = 1'b1;
    change    = '0;
    on_off    = '0;
    clr_flags = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    check_all("reset", 0, 0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;

    // Two on, one off -> net +1.
    cycle(4'b0111, 4'b0101, 1'b0);
    check_all("mixed", 1, 1, 1'b0, 1'b0, 1'b0);

    cycle(4'b0000, 4'b0000, 1'b0);
    check("idle.count", 32'(counter_out), 32'd1);

    // One on, one off cancel with no flag effect.
    cycle(4'b0011, 4'b0001, 1'b0);
    check_all("balanced", 1, 1, 1'b0, 1'b0, 1'b0);

    // Underflow from zero, then clear.
    dec_by(1);
    check("dec0.count", 32'(counter_out), 32'd0);
    cycle(4'b1111, 4'b0000, 1'b0);
    check_all("udf", 0, 1, 1'b0, 1'b0, 1'b1);
    cycle(4'b0000, 4'b0000, 1'b1);
    check_all("udf_clr", 0, 0, 1'b0, 1'b0, 1'b0);

    // Underflow in the same cycle as clr_flags: set wins.
    cycle(4'b1111, 4'b0000, 1'b1);
    check("udf_setwins", 32'(udf), 32'd1);
    cycle(4'b0000, 4'b0000, 1'b1);
    check("udf_clr2", 32'(udf), 32'd0);

    // Climb to 253 (alarm rises on the way past 200), then overflow.
    inc_by(253);
    check_all("at253", 253, 253, 1'b1, 1'b0, 1'b0);
    cycle(4'b1111, 4'b1111, 1'b0);
    check_all("ovf", 255, 255, 1'b1, 1'b1, 1'b0);
    cycle(4'b1111, 4'b1111, 1'b0);
    check_all("ovf_hold", 255, 255, 1'b1, 1'b1, 1'b0);
    cycle(4'b0000, 4'b0000, 1'b1);
    check_all("ovf_clr", 255, 255, 1'b1, 1'b0, 1'b0);

    // Hysteresis ramp: down to 148 clears alarm, +1 steps up to 201.
    dec_by(107);
    check_all("at148", 148, 255, 1'b0, 1'b0, 1'b0);
    for (int k = 149; k <= 199; k++) cycle(4'b0001, 4'b0001, 1'b0);
    check("ramp199.count", 32'(counter_out), 32'd199);
    check("ramp199.alarm", 32'(alarm), 32'd0);
    cycle(4'b0001, 4'b0001, 1'b0);
    check("ramp200.count", 32'(counter_out), 32'd200);
    check("ramp200.alarm", 32'(alarm), 32'd1);
    cycle(4'b0001, 4'b0001, 1'b0);
    check("ramp201.alarm", 32'(alarm), 32'd1);
    for (int k = 200; k >= 151; k--) cycle(4'b0001, 4'b0000, 1'b0);
    check("down151.count", 32'(counter_out), 32'd151);
    check("down151.alarm", 32'(alarm), 32'd1);
    cycle(4'b0001, 4'b0000, 1'b0);
    check("down150.count", 32'(counter_out), 32'd150);
    check("down150.alarm", 32'(alarm), 32'd0);

    // Peak re-arm: 220, clear, down to 180, clear, +1.
    inc_by(70);
    cycle(4'b0000, 4'b0000, 1'b1);
    check_all("pk220", 220, 220, 1'b1, 1'b0, 1'b0);
    dec_by(40);
    check("pk180.peak_before", 32'(peak_out), 32'd220);
    cycle(4'b0000, 4'b0000, 1'b1);
    check_all("pk180", 180, 180, 1'b1, 1'b0, 1'b0);
    cycle(4'b0001, 4'b0001, 1'b0);
    check_all("pk181", 181, 181, 1'b1, 1'b0, 1'b0);

    // Reach 210 with alarm and ovf set, then assert rst between edges.
    inc_by(74);
    cycle(4'b1111, 4'b1111, 1'b0);
    dec_by(45);
    check_all("pre_rst", 210, 255, 1'b1, 1'b1, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    check_all("async_rst", 0, 0, 1'b0, 1'b0, 1'b0);

    // Inputs ignored while held in reset.
    cycle(4'b1111, 4'b1111, 1'b0);
    check_all("rst_hold", 0, 0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    cycle(4'b0001, 4'b0001, 1'b0);
    check_all("post_rst", 1, 1, 1'b0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/active_device_monitor.md
ACTIVE_DEVICE_MONITOR -- requirements
Module: active_device_monitor

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, the counter and peak width in bits.
REQ-002 The block SHALL have parameter N_CH, default 4, the number of independent device-event channels (N_CH >= 1).
REQ-003 The block SHALL have parameter MAX_COUNT, default 2**WIDTH-1, the saturation ceiling.
REQ-004 The block SHALL have parameter HI_THRESH, default 200, the alarm set level; LO_THRESH, default 150, the alarm clear level; LO_THRESH < HI_THRESH <= MAX_COUNT.
REQ-005 clk  input  1  single clock; all state updates on its rising edge.
REQ-006 rst  input  1  reset, asynchronous, active-high.
REQ-007 change  input  N_CH  per-channel event strobe; bit i high = channel i reports one device change this cycle.
REQ-008 on_off  input  N_CH  per-channel direction; 1 = device switched on (+1), 0 = switched off (-1); ignored where change[i]=0.
REQ-009 clr_flags  input  1  clears sticky flags and re-arms the peak tracker.
REQ-010 counter_out  output  WIDTH  active-device count.
REQ-011 peak_out  output  WIDTH  highest counter_out since reset or last clr_flags.
REQ-012 alarm  output  1  high-occupancy alarm with hysteresis.
REQ-013 ovf  output  1  sticky: a cycle's result exceeded MAX_COUNT.
REQ-014 udf  output  1  sticky: a cycle's result went below 0.

Function
REQ-015 Each cycle the block SHALL compute ups = popcount(change & on_off), downs = popcount(change & ~on_off), raw = counter_out + ups - downs, in signed arithmetic wide enough that no intermediate wraps.
REQ-016 counter_out SHALL load clamp(raw, 0, MAX_COUNT) on the next rising edge (1-cycle latency); never wraps.
REQ-017 No change bits set SHALL leave counter_out unchanged; equal ups and downs SHALL leave it unchanged with no flag effect.
REQ-018 raw > MAX_COUNT SHALL set ovf; raw < 0 SHALL set udf; both stay high until clr_flags or rst.
REQ-019 clr_flags SHALL clear ovf/udf on the next edge, except a flag whose condition occurs in the same cycle, which SHALL be set (set wins).
REQ-020 peak_out SHALL load max(peak_out, next counter_out) each edge; with clr_flags it SHALL load next counter_out.
REQ-021 Alarm FSM states NORMAL (alarm=0) and ALARM (alarm=1); NORMAL->ALARM when next counter_out >= HI_THRESH; ALARM->NORMAL when next counter_out <= LO_THRESH; otherwise hold.
REQ-022 alarm SHALL change on the same edge that counter_out crosses a threshold (evaluated on next count, registered output).
REQ-023 All outputs SHALL be registered; no combinational input-to-output path.

Reset
REQ-024 rst high SHALL immediately, independent of clk, force counter_out=0, peak_out=0, alarm=0 (NORMAL), ovf=0, udf=0.
REQ-025 While rst is high inputs SHALL be ignored; first update occurs on the first rising edge after rst deasserts.
REQ-026 rst asserted mid-operation (any count, ALARM state, flags set) SHALL yield exactly the REQ-024 values.

Verification (defaults)
REQ-027 Reset then change=4'b0111, on_off=4'b0101 one cycle -> counter_out=1, peak_out=1, no flags.
REQ-028 From 0, change=4'b1111, on_off=4'b0000 -> counter_out=0, udf=1; then clr_flags one cycle with no events -> udf=0.
REQ-029 From 253, change=4'b1111, on_off=4'b1111 -> counter_out=255, ovf=1, peak_out=255; repeat -> stays 255.
REQ-030 Ramp 148->201 by +1 per cycle: alarm rises on edge where counter_out=200; ramp down: alarm stays high at 151, falls on edge where counter_out=150.
REQ-031 Count 220, peak 220, decrement to 180, pulse clr_flags -> peak_out=180; next +1 -> peak_out=181.
REQ-032 Count 210, alarm=1, ovf=1; assert rst between clock edges -> all outputs 0 before next edge.
